l2_victim_writeback: RTL
========================

L2_VICTIM_WRITEBACK -- requirements
Module: l2_victim_writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports as follows:
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 evict_req  in  1  L2 controller requests eviction of the LRU-selected way; held high until evict_ack seen.
REQ-005 evict_way  in  2  victim way, taken from the L2 LRU output.
REQ-006 evict_index  in  6  L2 set index of victim.
REQ-007 evict_valid  in  1  victim line valid bit.
REQ-008 evict_dirty  in  1  victim line dirty bit.
REQ-009 evict_tag  in  6  victim tag.
REQ-010 evict_data  in  128  victim line data.
REQ-011 pmem_resp  in  1  physical memory write completion, one-cycle pulse.
REQ-012 pmem_write  out  1  write request to physical memory, level, held until pmem_resp.
REQ-013 pmem_address  out  16  line address {tag, index, 4'b0000}.
REQ-014 pmem_wdata  out  128  captured line data.
REQ-015 clear_dirty  out  1  one-cycle pulse telling the L2 arrays to clear the dirty bit of {clear_way, clear_index}.
REQ-016 clear_way  out  2  captured way.
REQ-017 clear_index  out  6  captured index.
REQ-018 evict_ack  out  1  one-cycle pulse: victim slot is free for refill.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 wb_count  out  16  saturating count of completed writebacks.

Function
REQ-021 FSM states SHALL be IDLE, WRITE, CLEAR, DONE; all outputs registered or decoded from state plus capture registers only.
REQ-022 In IDLE with evict_req=1, the block SHALL capture way, index, tag, data into internal registers at that edge.
REQ-023 IDLE->WRITE if evict_valid & evict_dirty; otherwise IDLE->DONE (clean or invalid victim, no memory traffic).
REQ-024 WRITE: pmem_write=1, pmem_address/pmem_wdata from capture registers, stable every cycle until pmem_resp.
REQ-025 WRITE->CLEAR on the edge where pmem_resp=1; pmem_write SHALL be 0 in the cycle after pmem_resp.
REQ-026 CLEAR: clear_dirty=1 for exactly one cycle; CLEAR->DONE unconditionally.
REQ-027 DONE: evict_ack=1 for exactly one cycle; DONE->IDLE unconditionally.
REQ-028 Latency: clean victim ack in cycle 1 after req sampled; dirty victim ack exactly 2 cycles after the pmem_resp cycle.
REQ-029 evict_req while busy=1 SHALL be ignored; captures SHALL not change outside IDLE.
REQ-030 pmem_resp outside WRITE SHALL be ignored (no state change, no count).
REQ-031 Input changes on evict_* during WRITE SHALL not affect pmem_address or pmem_wdata.
REQ-032 wb_count SHALL increment by 1 on each accepted pmem_resp in WRITE and hold at 16'hFFFF.
REQ-033 clear_way/clear_index SHALL equal captured values in all non-IDLE states.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, pmem_write=0, clear_dirty=0, evict_ack=0, busy=0, wb_count=0, capture registers=0, pmem_address=0, pmem_wdata=0, independent of clk.
REQ-035 Reset asserted mid-WRITE SHALL abandon the write with no ack and no dirty clear; first request after rst_n rises SHALL be sampled normally.

Verification
REQ-036 Clean victim: req, valid=1, dirty=0, way=2, index=5 -> no pmem_write, evict_ack pulse cycle 1, no clear_dirty, wb_count=0.
REQ-037 Dirty victim: tag=6'h2A, index=6'h11, data=128'hDEAD...BEEF, pmem_resp after 4 cycles -> pmem_address=16'hA910, data stable 4 cycles, clear_dirty pulse way/index correct, ack 2 cycles after resp, wb_count=1.
REQ-038 Stray pmem_resp in IDLE and CLEAR plus evict_* changed during WRITE -> no state change, address/data unchanged, wb_count unaffected.
REQ-039 Reset pulse during WRITE -> pmem_write low asynchronously, no ack; next dirty request completes normally.
REQ-040 Force wb_count to 16'hFFFE, perform 3 dirty writebacks -> reads 16'hFFFF and holds.

Source files
------------

// File: rtl/l2_victim_writeback.sv
// L2 victim writeback engine.
// Captures an evicted line, writes it back if dirty, clears dirty, acks.
module l2_victim_writeback (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         evict_req,
  input  logic [1:0]   evict_way,
  input  logic [5:0]   evict_index,
  input  logic         evict_valid,
  input  logic         evict_dirty,
  input  logic [5:0]   evict_tag,
  input  logic [127:0] evict_data,
  input  logic         pmem_resp,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic         clear_dirty,
  output logic [1:0]   clear_way,
  output logic [5:0]   clear_index,
  output logic         evict_ack,
  output logic         busy,
  output logic [15:0]  wb_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic [1:0]     r_way;
  logic [5:0]     r_index;
  logic [5:0]     r_tag;
  logic [127:0]   r_data;
  logic [15:0]    r_wb_count;
  logic           w_need_wb;

  assign w_need_wb = evict_valid & evict_dirty;

  // Control FSM; captures victim only when idle so later input
  // changes cannot disturb an in-flight writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_way      <= '0;
      r_index    <= '0;
      r_tag      <= '0;
      r_data     <= '0;
      r_wb_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (evict_req) begin
            r_way   <= evict_way;
            r_index <= evict_index;
            r_tag   <= evict_tag;
            r_data  <= evict_data;
            r_state <= w_need_wb ? S_WRITE : S_DONE;
          end
        end
        S_WRITE: begin
          if (pmem_resp) begin
            r_state <= S_CLEAR;
            if (r_wb_count != 16'hFFFF)
              r_wb_count <= r_wb_count + 16'd1;
          end
        end
        S_CLEAR: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pmem_write   = (r_state == S_WRITE);
  assign clear_dirty  = (r_state == S_CLEAR);
  assign evict_ack    = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign pmem_address = {r_tag, r_index, 4'b0000};
  assign pmem_wdata   = r_data;
  assign clear_way    = r_way;
  assign clear_index  = r_index;
  assign wb_count     = r_wb_count;

endmodule
